// File: rtl/inv_mix_columns.sv
// Inverse MixColumns round stage: column-serial by default, one column per cycle.
// Define INV_MIX_COLUMNS_PARALLEL_EN for a single-cycle, fully parallel datapath.
module inv_mix_columns (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic [127:0] state_i,
  input  logic         en_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [127:0] state_o
);

  localparam int unsigned COL_W = 32;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through the inverse matrix, built from xtime chains.
  function automatic logic [COL_W-1:0] inv_col(input logic [COL_W-1:0] c);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] m11 [4];
    logic [7:0] m13 [4];
    logic [7:0] m14 [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]   = c[COL_W-1-8*i -: 8];
      x2     = xt(a[i]);
      x4     = xt(x2);
      x8     = xt(x4);
      m9[i]  = x8 ^ a[i];
      m11[i] = x8 ^ x2 ^ a[i];
      m13[i] = x8 ^ x4 ^ a[i];
      m14[i] = x8 ^ x4 ^ x2;
    end
    return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
            m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
            m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
            m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
  endfunction

`ifdef INV_MIX_COLUMNS_PARALLEL_EN

  logic [127:0] w_result;

  assign w_result = {inv_col(state_i[127:96]), inv_col(state_i[95:64]),
                     inv_col(state_i[63:32]),  inv_col(state_i[31:0])};
  assign busy_o   = 1'b0;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_o <= '0;
      done_o  <= 1'b0;
    end else begin
      done_o <= en_i;
      if (en_i) state_o <= w_result;
    end
  end

`else

  typedef enum logic {IDLE, RUN} state_t;

  state_t       r_state;
  logic [1:0]   r_col;
  logic [127:0] r_work;
  logic [COL_W-1:0] w_col_in;
  logic [COL_W-1:0] w_col_out;
  logic [127:0] w_work_next;

  // Single shared column transformer; the counter selects which column it sees.
  always_comb begin
    w_col_in    = r_work[127:96];
    w_work_next = r_work;
    unique case (r_col)
      2'd0: w_col_in = r_work[127:96];
      2'd1: w_col_in = r_work[95:64];
      2'd2: w_col_in = r_work[63:32];
      2'd3: w_col_in = r_work[31:0];
    endcase
    w_col_out = inv_col(w_col_in);
    unique case (r_col)
      2'd0: w_work_next[127:96] = w_col_out;
      2'd1: w_work_next[95:64]  = w_col_out;
      2'd2: w_work_next[63:32]  = w_col_out;
      2'd3: w_work_next[31:0]   = w_col_out;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_col   <= 2'd0;
      r_work  <= '0;
      state_o <= '0;
      done_o  <= 1'b0;
      busy_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (r_state)
        IDLE: begin
          if (en_i) begin
            r_work  <= state_i;
            r_col   <= 2'd0;
            r_state <= RUN;
            busy_o  <= 1'b1;
          end
        end
        RUN: begin
          r_work <= w_work_next;
          r_col  <= r_col + 2'd1;
          // Result is published only once the last column is in place.
          if (r_col == 2'd3) begin
            state_o <= w_work_next;
            done_o  <= 1'b1;
            busy_o  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`endif

endmodule

// File: tb/tb_inv_mix_columns.sv
// Directed and random checks for inv_mix_columns against an independent GF(2^8) model.
module tb_inv_mix_columns;

`ifdef INV_MIX_COLUMNS_PARALLEL_EN
  localparam int EXP_WAIT   = 0;
  localparam int EXP_PERIOD = 1;
  localparam bit EXP_BUSY   = 1'b0;
`else
  localparam int EXP_WAIT   = 4;
  localparam int EXP_PERIOD = 5;
  localparam bit EXP_BUSY   = 1'b1;
`endif

  localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V1_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN  = 128'h4d7ebdf8_d5d5d7d6_00000000_ffffffff;
  localparam logic [127:0] V2_OUT = 128'h2d26314c_d4d4d4d5_00000000_ffffffff;

  logic         clk_i = 1'b0;
  logic         rst_n;
  logic [127:0] state_i;
  logic         en_i;
  logic         busy_o;
  logic         done_o;
  logic [127:0] state_o;

  int n_checks = 0;
  int n_errors = 0;

  inv_mix_columns dut (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .state_i (state_i),
    .en_i    (en_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .state_o (state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Shift-and-add GF(2^8) multiply, modulus 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_model(input logic [127:0] s, input bit inv);
    logic [7:0] coef [4];
    logic [7:0] acc;
    logic [127:0] r;
    if (inv) begin
      coef[0] = 8'd14; coef[1] = 8'd11; coef[2] = 8'd13; coef[3] = 8'd9;
    end else begin
      coef[0] = 8'd2;  coef[1] = 8'd3;  coef[2] = 8'd1;  coef[3] = 8'd1;
    end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(coef[(j - row) & 3], s[127 - 8*(4*c + j) -: 8]);
        r[127 - 8*(4*c + row) -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic run_one(input string tag, input logic [127:0] din, input logic [127:0] exp);
    logic [127:0] prev;
    int n;
    prev    = state_o;
    state_i = din;
    en_i    = 1'b1;
    step();
    en_i = 1'b0;
    check({tag, "_busy"}, 128'(busy_o), 128'(EXP_BUSY));
    n = 0;
    while (!done_o && n < 12) begin
      check({tag, "_hold"}, state_o, prev);
      step();
      n++;
    end
    check({tag, "_lat"}, 128'(n), 128'(EXP_WAIT));
    check({tag, "_res"}, state_o, exp);
    step();
    check({tag, "_done_fall"}, 128'(done_o), 128'(0));
    check({tag, "_keep"}, state_o, exp);
  endtask

  initial begin
    logic [127:0] vecs [2];
    logic [127:0] exps [2];
    logic [127:0] s;
    int idx, cyc, last, pulses;
    logic [127:0] seen;

    rst_n   = 1'b0;
    en_i    = 1'b0;
    state_i = '0;
    #12;
    check("rst_state", state_o, 128'(0));
    check("rst_done", 128'(done_o), 128'(0));
    check("rst_busy", 128'(busy_o), 128'(0));
    rst_n = 1'b1;

    run_one("vec1", V1_IN, V1_OUT);

    // Reset while the third column is pending.
    state_i = V2_IN;
    en_i    = 1'b1;
    step();
    en_i = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("midrst_state", state_o, 128'(0));
    check("midrst_done", 128'(done_o), 128'(0));
    check("midrst_busy", 128'(busy_o), 128'(0));
    #2;
    rst_n = 1'b1;

    run_one("vec2", V2_IN, V2_OUT);

`ifndef INV_MIX_COLUMNS_PARALLEL_EN
    // Starts during RUN must be dropped.
    state_i = V1_IN;
    en_i    = 1'b1;
    step();
    check("ign_busy0", 128'(busy_o), 128'(1));
    state_i = V2_IN;
    step();
    check("ign_busy1", 128'(busy_o), 128'(1));
    step();
    check("ign_busy2", 128'(busy_o), 128'(1));
    en_i = 1'b0;
    step();
    check("ign_busy3", 128'(busy_o), 128'(1));
    pulses = 0;
    seen   = '0;
    for (int i = 0; i < 8; i++) begin
      if (done_o) begin
        pulses++;
        seen = state_o;
      end
      step();
    end
    check("ign_pulses", 128'(pulses), 128'(1));
    check("ign_res", seen, V1_OUT);
`endif

    // Continuous en_i with alternating vectors.
    vecs[0] = V1_IN;  vecs[1] = V2_IN;
    exps[0] = V1_OUT; exps[1] = V2_OUT;
    idx     = 0;
    cyc     = 0;
    last    = -1;
    state_i = vecs[0];
    en_i    = 1'b1;
    while (idx < 4 && cyc < 60) begin
      step();
      cyc++;
      if (done_o) begin
        check("b2b_res", state_o, exps[idx % 2]);
        if (last >= 0) check("b2b_period", 128'(cyc - last), 128'(EXP_PERIOD));
        last = cyc;
        idx++;
        state_i = vecs[idx % 2];
      end
    end
    en_i = 1'b0;
    check("b2b_count", 128'(idx), 128'(4));
    step();
    step();

    for (int k = 0; k < 6; k++) begin
      s = {$urandom, $urandom, $urandom, $urandom};
      run_one("rand", s, mix_model(s, 1'b1));
      run_one("trip", mix_model(s, 1'b0), s);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inv_mix_columns.md
# inv_mix_columns

Decryption-side InvMixColumns stage of the Rijndael datapath: applies the inverse column mix over GF(2^8) to a 128-bit state. It sits in the inverse-cipher round between AddRoundKey and InvShiftRows/InvSubBytes, and uses the same en_i/done_o handshake as the other round stages. The default build is column-serial (one column per cycle) to save area. A compile-time option selects a single-cycle, fully parallel datapath.

## Interface
Parameters:
- none

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- state_i  input  128  input state; sampled only on an accepted start
- en_i  input  1  start request; accepted only when idle
- busy_o  output  1  high while a transform is in progress; reset 0
- done_o  output  1  one-cycle pulse; state_o is valid on this cycle; reset 0
- state_o  output  128  result register; holds the last result until the next completion; reset 0

## Operation
- Byte order: state_i[127:120] is byte 0.
- Column c occupies bytes 4c..4c+3. Column 0 is [127:96] and column 3 is [31:0].
- Per column, for input bytes (a0,a1,a2,a3):
  - b0 = 14·a0 ^ 11·a1 ^ 13·a2 ^ 9·a3
  - b1 = 9·a0 ^ 14·a1 ^ 11·a2 ^ 13·a3
  - b2 = 13·a0 ^ 9·a1 ^ 14·a2 ^ 11·a3
  - b3 = 11·a0 ^ 13·a1 ^ 9·a2 ^ 14·a3
- GF(2^8) multiplication uses modulus x^8+x^4+x^3+x+1 (0x11B).
- Multiplication is built from xtime chains: 9 = 8^1, 11 = 8^2^1, 13 = 8^4^1, 14 = 8^4^2. All intermediates are 8 bits, reduced on every xtime.
- Serial FSM has two states, IDLE and RUN, with a 2-bit column counter col.
- IDLE:
  - If en_i is high, capture state_i into the internal work register, set col=0, go to RUN, and set busy_o=1.
  - If en_i is low, stay in IDLE and keep done_o=0.
- RUN:
  - Each cycle, replace column col of the work register with its transformed value, then increment col.
  - When col==3:
    - write the fully transformed word to state_o;
    - pulse done_o;
    - clear busy_o;
    - return to IDLE.
- en_i while in RUN is ignored. There is no queueing, and state_i is not re-sampled.
- state_o never exposes partial results. It changes only on the completion edge.
- Reset mid-operation: the asynchronous clear returns the FSM to IDLE with col=0, the work register at 0, state_o at 0, done_o at 0 and busy_o at 0. The in-flight operation is discarded.

## Timing
- Serial mode:
  - en_i is accepted at rising edge k.
  - Columns 0..3 are processed at edges k+1..k+4.
  - state_o updates and done_o rises at edge k+4 and falls at edge k+5. Latency is 4 cycles.
  - busy_o is high from edge k to edge k+4.
- Back-to-back operation: en_i held high in the done_o cycle is accepted at edge k+5, because the FSM is already in IDLE. Sustained throughput is one block per 5 cycles.
- done_o is high for exactly one cycle per accepted start, never for a rejected one.
- Parallel mode: see Configuration.

## Configuration
- INV_MIX_COLUMNS_PARALLEL_EN
  - Defined:
    - all four columns are computed combinationally from state_i;
    - state_o <= InvMixColumns(state_i) and done_o <= 1 at the edge where en_i=1. Latency is 1 cycle;
    - when en_i=0, state_o holds its value and done_o <= 0;
    - the FSM and work register are removed, and busy_o is tied to 0;
    - en_i may be high every cycle, giving a throughput of one block per cycle.
  - Undefined: the column-serial FSM described above, with 4-cycle latency.
- The ports are identical in both builds.

## Test plan
- Reset: assert rst_n=0 mid-RUN (col=2) -> state_o=0, done_o=0 and busy_o=0 immediately; the next en_i starts a fresh 4-cycle operation.
- Known vector: state_i=0x8e4da1bc_9fdc589d_01010101_c6c6c6c6 with a single en_i pulse -> state_o=0xdb135345_f20a225c_01010101_c6c6c6c6, with done_o high exactly 4 cycles after acceptance (1 cycle in the parallel build).
- Second vector: state_i=0x4d7ebdf8_d5d5d7d6_00000000_ffffffff -> state_o=0x2d26314c_d4d4d4d5_00000000_ffffffff.
- en_i pulsed at cycles +1 and +2 after acceptance with a different state_i -> ignored:
  - exactly one done_o pulse;
  - the result matches the first state_i;
  - busy_o stays high throughout.
- en_i held high continuously with the vectors above alternating -> serial build: a done_o pulse every 5 cycles with correct results in order; parallel build: a done_o pulse every cycle.
- Random states, checked against a reference model; also compose with forward MixColumns -> each result equals the model, and the round-trip returns the original state. state_o is stable between done_o pulses.
